// File: rtl/sphere_collide_fx_if.sv
// Handshake and data bundle for the sphere_collide_fx narrow-phase unit.
// The slave modport is the collision unit; the master modport is the producer/consumer side.
interface sphere_collide_fx_if #(
   parameter int WIDTH = 32,
   parameter int ID_W  = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x1, y1, z1, r1;
   logic [WIDTH-1:0] x2, y2, z2, r2;
   logic [ID_W-1:0]  g1, g2;
   logic             out_valid;
   logic             out_ready;
   logic             ret;
   logic [WIDTH-1:0] depth;
   logic [WIDTH-1:0] normalx, normaly, normalz;
   logic [ID_W-1:0]  out_g1, out_g2;

   modport slave (
      input  in_valid, x1, y1, z1, r1, x2, y2, z2, r2, g1, g2, out_ready,
      output in_ready, out_valid, ret, depth, normalx, normaly, normalz, out_g1, out_g2
   );

   modport master (
      output in_valid, x1, y1, z1, r1, x2, y2, z2, r2, g1, g2, out_ready,
      input  in_ready, out_valid, ret, depth, normalx, normaly, normalz, out_g1, out_g2
   );
endinterface

// File: rtl/sphere_collide_fx.sv
// Fixed-point sphere-sphere collision: bit-serial sqrt for distance, optional serial divides for the unit normal.
// Define SPHERE_COLLIDE_NORMAL_EN to build the NORM state and dividers; otherwise normal* stay 0.
//
// state   | meaning
// S_IDLE  | waiting for a pair, in_ready high
// S_DIFF  | centre differences and radius sum
// S_SQR   | squared distance and squared radius sum
// S_CMP   | hit test; a miss goes straight to S_DONE
// S_SQRT  | restoring square root, one result bit per cycle
// S_DEPTH | penetration depth, divider setup
// S_NORM  | three serial divides, one per axis
// S_DONE  | result held until out_ready
module sphere_collide_fx #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16,
   parameter int ID_W  = 32
) (
   input  logic clk,
   input  logic rst,
   sphere_collide_fx_if.slave bus
);
   localparam int SQ_IT = WIDTH + 2;
   localparam int DW    = 2*WIDTH + 4;
   localparam int RW    = SQ_IT;
   localparam int REMW  = RW + 2;
   localparam int CW    = $clog2(SQ_IT + 1);

   if (FRAC >= WIDTH - 1) begin : g_bad_frac
      $error("FRAC must be smaller than WIDTH-1");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_DIFF, S_SQR, S_CMP, S_SQRT, S_DEPTH, S_NORM, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] x1_q, y1_q, z1_q, r1_q, x2_q, y2_q, z2_q, r2_q;
   logic [WIDTH:0]   dx, dy, dz, rs;
   logic [DW-1:0]    dsq, rs2, sq_rad;
   logic [REMW-1:0]  sq_rem, rem_sh, trial;
   logic [RW-1:0]    sq_root;
   logic [CW-1:0]    sq_cnt;
   logic             sq_ge;
   logic [RW:0]      depth_full;
   logic [WIDTH-1:0] depth_sat;
   logic             ret_r;
   logic [WIDTH-1:0] depth_r, nx_r, ny_r, nz_r;
   logic [ID_W-1:0]  og1_r, og2_r;

   function automatic logic [WIDTH:0] mag(input logic [WIDTH:0] v);
      return v[WIDTH] ? (~v + (WIDTH+1)'(1)) : v;
   endfunction

   function automatic logic [DW-1:0] sq(input logic [WIDTH:0] v);
      logic [DW-1:0] m;
      m = DW'(mag(v));
      return m * m;
   endfunction

   assign rem_sh     = (sq_rem << 2) | REMW'(sq_rad[DW-1 -: 2]);
   assign trial      = {sq_root, 2'b01};
   assign sq_ge      = (rem_sh >= trial);
   assign depth_full = (RW+1)'(rs) - {1'b0, sq_root};
   assign depth_sat  = (|depth_full[RW:WIDTH]) ? '1 : depth_full[WIDTH-1:0];

`ifdef SPHERE_COLLIDE_NORMAL_EN
   localparam int DVW = RW + FRAC;
   localparam int DCW = $clog2(FRAC + 1);

   logic [DVW-1:0]   dv_rem, dv_dsh;
   logic [FRAC-1:0]  dv_q;
   logic [FRAC:0]    q_fin;
   logic [DCW-1:0]   dv_cnt;
   logic [1:0]       axis;
   logic             dv_ge, dv_last;
   logic [WIDTH:0]   cur_v, nxt_v;
   logic [WIDTH-1:0] nrm_res;

   assign dv_ge   = (dv_rem >= dv_dsh);
   assign q_fin   = {dv_q, dv_ge};
   assign dv_last = (dv_cnt == DCW'(FRAC));
   assign cur_v   = (axis == 2'd0) ? dx : (axis == 2'd1) ? dy : dz;
   assign nxt_v   = (axis == 2'd0) ? dy : dz;
   // Truncated magnitude with the sign re-applied rounds toward zero.
   assign nrm_res = cur_v[WIDTH] ? (WIDTH'(0) - WIDTH'(q_fin)) : WIDTH'(q_fin);
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.in_valid) state_nxt = S_DIFF;
         S_DIFF:  state_nxt = S_SQR;
         S_SQR:   state_nxt = S_CMP;
         S_CMP:   state_nxt = (dsq <= rs2) ? S_SQRT : S_DONE;
         S_SQRT:  if (sq_cnt == CW'(SQ_IT - 1)) state_nxt = S_DEPTH;
`ifdef SPHERE_COLLIDE_NORMAL_EN
         S_DEPTH: state_nxt = (sq_root == '0) ? S_DONE : S_NORM;
         S_NORM:  if (dv_last && axis == 2'd2) state_nxt = S_DONE;
`else
         S_DEPTH: state_nxt = S_DONE;
`endif
         S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ret_r   <= 1'b0;
         depth_r <= '0;
         nx_r    <= '0;
         ny_r    <= '0;
         nz_r    <= '0;
         og1_r   <= '0;
         og2_r   <= '0;
      end else begin
         case (state)
            S_IDLE: if (bus.in_valid) begin
               x1_q  <= bus.x1;  y1_q <= bus.y1;  z1_q <= bus.z1;  r1_q <= bus.r1;
               x2_q  <= bus.x2;  y2_q <= bus.y2;  z2_q <= bus.z2;  r2_q <= bus.r2;
               og1_r <= bus.g1;
               og2_r <= bus.g2;
            end
            S_DIFF: begin
               dx <= {x1_q[WIDTH-1], x1_q} - {x2_q[WIDTH-1], x2_q};
               dy <= {y1_q[WIDTH-1], y1_q} - {y2_q[WIDTH-1], y2_q};
               dz <= {z1_q[WIDTH-1], z1_q} - {z2_q[WIDTH-1], z2_q};
               rs <= {1'b0, r1_q} + {1'b0, r2_q};
            end
            S_SQR: begin
               dsq <= sq(dx) + sq(dy) + sq(dz);
               rs2 <= DW'(rs) * DW'(rs);
            end
            S_CMP: begin
               sq_rad  <= dsq;
               sq_rem  <= '0;
               sq_root <= '0;
               sq_cnt  <= '0;
               if (dsq > rs2) begin
                  ret_r   <= 1'b0;
                  depth_r <= '0;
                  nx_r    <= '0;
                  ny_r    <= '0;
                  nz_r    <= '0;
               end
            end
            S_SQRT: begin
               sq_rad  <= sq_rad << 2;
               sq_rem  <= sq_ge ? (rem_sh - trial) : rem_sh;
               sq_root <= (sq_root << 1) | RW'(sq_ge);
               sq_cnt  <= sq_cnt + CW'(1);
            end
            S_DEPTH: begin
               ret_r   <= 1'b1;
               depth_r <= depth_sat;
               nx_r    <= '0;
               ny_r    <= '0;
               nz_r    <= '0;
`ifdef SPHERE_COLLIDE_NORMAL_EN
               // Coincident centres have no direction; report +x.
               if (sq_root == '0) nx_r <= WIDTH'(1) << FRAC;
               dv_rem <= DVW'(mag(dx)) << FRAC;
               dv_dsh <= DVW'(sq_root) << FRAC;
               dv_q   <= '0;
               dv_cnt <= '0;
               axis   <= 2'd0;
`endif
            end
`ifdef SPHERE_COLLIDE_NORMAL_EN
            S_NORM: begin
               if (dv_last) begin
                  case (axis)
                     2'd0:    nx_r <= nrm_res;
                     2'd1:    ny_r <= nrm_res;
                     default: nz_r <= nrm_res;
                  endcase
                  dv_rem <= DVW'(mag(nxt_v)) << FRAC;
                  dv_dsh <= DVW'(sq_root) << FRAC;
                  dv_q   <= '0;
                  dv_cnt <= '0;
                  axis   <= axis + 2'd1;
               end else begin
                  dv_rem <= dv_ge ? (dv_rem - dv_dsh) : dv_rem;
                  dv_dsh <= dv_dsh >> 1;
                  dv_q   <= q_fin[FRAC-1:0];
                  dv_cnt <= dv_cnt + DCW'(1);
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE) && !rst;
   assign bus.out_valid = (state == S_DONE);
   assign bus.ret       = ret_r;
   assign bus.depth     = depth_r;
   assign bus.normalx   = nx_r;
   assign bus.normaly   = ny_r;
   assign bus.normalz   = nz_r;
   assign bus.out_g1    = og1_r;
   assign bus.out_g2    = og2_r;
endmodule
